timer_dev: RTL

- Memory-mapped countdown timer: the responder (slave) end of the CPU data-memory bus.
- Address decode upstream asserts `sel` for this device's 16-byte window (TIMER0 at 0x7F00, TIMER1 at 0x7F10).
- The block decodes `addr[3:2]` and answers reads combinationally.
- It counts down from a programmable preset and drives one interrupt line into the CP0 hardware-interrupt vector.

---
 rtl/timer_dev.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers and a maskable interrupt line.
// Defining TIMER_PRESCALE_EN adds the CTRL[15:8] PSC field and an 8-bit prescale counter.
module timer_dev #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned PRESET_RST = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [3:2]  addr,
   input  logic [3:0]  we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned PSC_W  = 8;

   localparam logic [1:0] OFF_CTRL    = 2'd0;
   localparam logic [1:0] OFF_PRESET  = 2'd1;
   localparam logic [1:0] OFF_COUNT   = 2'd2;
   localparam logic [1:0] MODE_RELOAD = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CNT,
      ST_INT
   } state_t;

   state_t             state;
   state_t             state_next;

   logic               en;
   logic [1:0]         mode;
   logic               im;
   logic [CNT_W-1:0]   preset;
   logic [CNT_W-1:0]   count;
   logic               irq_flag;
   logic               pulse;
   logic [PSC_W-1:0]   psc_rd;

   logic               wr;
   logic               wr_ctrl;
   logic               wr_preset;
   logic               reload;
   logic               tick;
   logic               load_cnt;
   logic               dec_cnt;
   logic               zero_cnt;
   logic               fire;

   logic               unused_wdata;

   assign wr        = sel && (we == 4'b1111);
   assign wr_ctrl   = wr && (addr == OFF_CTRL);
   assign wr_preset = wr && (addr == OFF_PRESET);
   assign reload    = (mode == MODE_RELOAD);

   assign unused_wdata = ^wdata;

`ifdef TIMER_PRESCALE_EN
   logic [PSC_W-1:0] psc;
   logic [PSC_W-1:0] psc_cnt;

   // COUNT only advances on edges where the prescale counter reaches PSC
   assign tick   = (psc_cnt == psc);
   assign psc_rd = psc;

   always_ff @(posedge clk) begin
      if (reset) begin
         psc <= '0;
      end else if (wr_ctrl) begin
         psc <= wdata[15:8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         psc_cnt <= '0;
      end else if (state == ST_LOAD) begin
         psc_cnt <= '0;
      end else if (state == ST_CNT && en) begin
         psc_cnt <= tick ? '0 : psc_cnt + PSC_W'(1);
      end
   end
`else
   assign tick   = 1'b1;
   assign psc_rd = '0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath strobes
   always_comb begin
      state_next = state;
      load_cnt   = 1'b0;
      dec_cnt    = 1'b0;
      zero_cnt   = 1'b0;
      fire       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            load_cnt   = 1'b1;
            state_next = ST_CNT;
         end
         ST_CNT: begin
            if (!en) begin
               state_next = ST_IDLE;
            end else if (tick) begin
               if (count > CNT_W'(1)) begin
                  dec_cnt = 1'b1;
               end else begin
                  zero_cnt   = 1'b1;
                  state_next = ST_INT;
               end
            end
         end
         ST_INT: begin
            fire       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // A software CTRL write on the one-shot expiry edge takes precedence over the EN clear
   always_ff @(posedge clk) begin
      if (reset) begin
         en   <= 1'b0;
         mode <= 2'b00;
         im   <= 1'b0;
      end else if (wr_ctrl) begin
         {im, mode, en} <= wdata[3:0];
      end else if (fire && !reload) begin
         en <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         preset <= CNT_W'(PRESET_RST);
      end else if (wr_preset) begin
         preset <= wdata[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load_cnt) begin
         count <= preset;
      end else if (dec_cnt) begin
         count <= count - CNT_W'(1);
      end else if (zero_cnt) begin
         count <= '0;
      end
   end

   // Set beats clear; auto-reload flags last exactly one cycle via pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_flag <= 1'b0;
         pulse    <= 1'b0;
      end else begin
         pulse <= fire && reload;
         if (fire) begin
            irq_flag <= 1'b1;
         end else if (wr_ctrl || wr_preset || pulse) begin
            irq_flag <= 1'b0;
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         OFF_CTRL:   rdata = {16'd0, psc_rd, 4'd0, im, mode, en};
         OFF_PRESET: rdata = DATA_W'(preset);
         OFF_COUNT:  rdata = DATA_W'(count);
         default:    rdata = '0;
      endcase
   end

   assign irq = im & irq_flag;

endmodule
